muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Sequencer for the EX-stage multi-cycle units: the iterative divider (start/ready/annul handshake) and the fixed-latency multiplier.
- Accepts one mult/multu/div/divu per EX-resident instruction, drives the unit, and raises the EX stall request until HI/LO results are captured.
- Holds the results stable until the instruction leaves EX. This prevents a re-start while the pipeline is stalled downstream.
- Flush and timeout abort an operation cleanly.

Parameters:
- MUL_LAT, 2, multiplier result latency in cycles after operands are applied; legal range 1..15.
- DIV_MAX_CYC, 40, watchdog limit on DIV_RUN cycles before abort; legal range 2..255.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- op_valid  input  1  EX holds a mul/div instruction
- op_sel  input  2  00 mult, 01 multu, 10 div, 11 divu
- src_a  input  32  rs operand (dividend / multiplicand)
- src_b  input  32  rt operand (divisor / multiplier)
- op_accept  input  1  EX hands the instruction to MEM this cycle
- flush  input  1  discard the current operation
- stallreq  output  1  stall request to the pipeline controller
- div_start  output  1  divider start level
- div_signed  output  1  signed-divide select
- div_opa  output  32  divider operand 1
- div_opb  output  32  divider operand 2
- div_annul  output  1  divider abort pulse
- div_result  input  64  {remainder, quotient}
- div_ready  input  1  divider result valid
- mul_signed  output  1  signed-multiply select
- mul_result  input  64  {hi, lo} product
- res_valid  output  1  hi_wdata/lo_wdata valid, HI/LO write enable
- hi_wdata  output  32  HI result
- lo_wdata  output  32  LO result
- div_timeout  output  1  last divide hit the watchdog

Behaviour:
- Reset rst: synchronous, active-high. Clock clk.
- On rst: state IDLE, counters 0, and the following outputs are 0: res_valid, hi_wdata, lo_wdata, div_timeout, div_annul, stallreq, div_start.
- States: IDLE, MUL_RUN, DIV_RUN, DONE.
- stallreq is combinational: op_valid & ~flush & state!=DONE.
- div_opa/div_opb = src_a/src_b while div_start=1, else 0.
- div_signed = (op_sel==10); mul_signed = (op_sel==00).
- IDLE:
  - op_valid & op_sel[1]=0 -> MUL_RUN, cnt=1.
  - op_valid & op_sel[1]=1 -> DIV_RUN, cnt=1, div_start=1 in this same cycle.
  - Entering an operation clears div_timeout.
  - Otherwise stay in IDLE.
- MUL_RUN: when cnt==MUL_LAT, capture hi/lo = mul_result and go to DONE; else cnt+1. Stall cycles = MUL_LAT+1; res_valid rises at T0+MUL_LAT+1, where T0 is the cycle IDLE sees the op.
- DIV_RUN:
  - div_start=1 until div_ready.
  - On div_ready: div_start=0 that cycle, capture hi=div_result[63:32] and lo=div_result[31:0], go to DONE.
  - If cnt reaches DIV_MAX_CYC without ready: div_annul pulses 1 cycle, hi=lo=0, div_timeout=1, go to DONE.
- DONE: res_valid=1 and results held, stallreq=0. op_accept -> IDLE, res_valid=0 next cycle. op_valid remaining high in DONE never restarts a unit.
- flush, any state: next state IDLE, res_valid=0, counters cleared. div_annul=1 for that one cycle if the state is DIV_RUN. Flush has priority over div_ready, counter expiry and op_accept the same cycle; no capture occurs.
- op_accept outside DONE is ignored.
- rst mid-operation behaves as flush but without div_annul. The divider resets from the same rst.

Optional Feature:
- Macro: MULDIV_DIVZERO_EN.
- Defined: a div/divu with src_b==0 seen in IDLE bypasses the divider. div_start stays 0, and the block goes directly to DONE next cycle with hi=src_a, lo=32'hFFFF_FFFF. stallreq is high for exactly 1 cycle.
- Undefined: divide-by-zero is issued to the divider like any other divide, and the result is whatever the divider returns.

Test Plan:
- multu 0xFFFFFFFF x 2, MUL_LAT=2 -> stallreq high 3 cycles, then res_valid with hi=0x00000001, lo=0xFFFFFFFE. Mult on the same operands -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- divu 100/7 with model divider (ready after 33 cycles) -> div_start high until ready, then hi=2, lo=14. div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div completes while op_accept is held 0 for 5 cycles -> res_valid/hi/lo stable for 5 cycles, div_start stays 0, no second start. Then op_accept -> IDLE.
- flush asserted on DIV_RUN cycle 10, together with div_ready -> div_annul 1 pulse, no capture, res_valid 0, IDLE next cycle.
- Divider that never readies, DIV_MAX_CYC=40 -> annul pulse at cycle 40, div_timeout=1, hi=lo=0, res_valid=1. Next op clears div_timeout.
- With MULDIV_DIVZERO_EN: div 0x1234/0 -> stallreq 1 cycle, hi=0x00001234, lo=0xFFFFFFFF, div_start never asserted.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// EX-stage sequencer for the iterative divider and fixed-latency multiplier.
// Optional macro MULDIV_DIVZERO_EN: divide-by-zero bypasses the divider.
module muldiv_ctrl #(
  parameter int MUL_LAT     = 2,
  parameter int DIV_MAX_CYC = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op_sel,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        op_accept,
  input  logic        flush,
  output logic        stallreq,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic        mul_signed,
  input  logic [63:0] mul_result,
  output logic        res_valid,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        div_timeout
);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [31:0] hi_nxt, lo_nxt;
  logic        res_valid_nxt, timeout_nxt;
  logic        start_c, annul_c, div_zero;

`ifdef MULDIV_DIVZERO_EN
  assign div_zero = (src_b == 32'd0);
`else
  assign div_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      hi_wdata    <= '0;
      lo_wdata    <= '0;
      res_valid   <= 1'b0;
      div_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      hi_wdata    <= hi_nxt;
      lo_wdata    <= lo_nxt;
      res_valid   <= res_valid_nxt;
      div_timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    hi_nxt        = hi_wdata;
    lo_nxt        = lo_wdata;
    res_valid_nxt = res_valid;
    timeout_nxt   = div_timeout;
    start_c       = 1'b0;
    annul_c       = 1'b0;
    if (flush) begin
      // flush wins over ready, expiry and accept: nothing is captured
      state_nxt     = IDLE;
      cnt_nxt       = '0;
      res_valid_nxt = 1'b0;
      annul_c       = (state == DIV_RUN);
    end else begin
      case (state)
        IDLE: if (op_valid) begin
          timeout_nxt = 1'b0;
          cnt_nxt     = 8'd1;
          if (!op_sel[1]) begin
            state_nxt = MUL_RUN;
          end else if (div_zero) begin
            state_nxt     = DONE;
            cnt_nxt       = '0;
            hi_nxt        = src_a;
            lo_nxt        = '1;
            res_valid_nxt = 1'b1;
          end else begin
            state_nxt = DIV_RUN;
            start_c   = 1'b1;
          end
        end
        MUL_RUN: if (cnt == 8'(MUL_LAT)) begin
          state_nxt     = DONE;
          cnt_nxt       = '0;
          {hi_nxt, lo_nxt} = mul_result;
          res_valid_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
        DIV_RUN: if (div_ready) begin
          state_nxt     = DONE;
          cnt_nxt       = '0;
          {hi_nxt, lo_nxt} = div_result;
          res_valid_nxt = 1'b1;
        end else if (cnt == 8'(DIV_MAX_CYC)) begin
          // watchdog: abort the divider and complete with a zero result
          annul_c       = 1'b1;
          state_nxt     = DONE;
          cnt_nxt       = '0;
          hi_nxt        = '0;
          lo_nxt        = '0;
          timeout_nxt   = 1'b1;
          res_valid_nxt = 1'b1;
        end else begin
          start_c = 1'b1;
          cnt_nxt = cnt + 8'd1;
        end
        DONE: if (op_accept) begin
          state_nxt     = IDLE;
          res_valid_nxt = 1'b0;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // the divider shares rst, so no annul is needed while reset is applied
  assign div_start  = start_c & ~rst;
  assign div_annul  = annul_c & ~rst;
  assign stallreq   = op_valid & ~flush & (state != DONE) & ~rst;
  assign div_opa    = div_start ? src_a : '0;
  assign div_opb    = div_start ? src_b : '0;
  assign div_signed = (op_sel == 2'b10);
  assign mul_signed = (op_sel == 2'b00);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl with behavioural multiplier/divider models.
module tb_muldiv_ctrl;
  localparam int MUL_LAT     = 2;
  localparam int DIV_MAX_CYC = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0, op_accept = 1'b0, flush = 1'b0;
  logic [1:0]  op_sel = 2'b00;
  logic [31:0] src_a = '0, src_b = '0;
  logic        stallreq, div_start, div_signed, div_annul, div_ready, mul_signed;
  logic [31:0] div_opa, div_opb, hi_wdata, lo_wdata;
  logic [63:0] div_result, mul_result;
  logic        res_valid, div_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .DIV_MAX_CYC(DIV_MAX_CYC)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_sel(op_sel),
    .src_a(src_a), .src_b(src_b), .op_accept(op_accept), .flush(flush),
    .stallreq(stallreq), .div_start(div_start), .div_signed(div_signed),
    .div_opa(div_opa), .div_opb(div_opb), .div_annul(div_annul),
    .div_result(div_result), .div_ready(div_ready), .mul_signed(mul_signed),
    .mul_result(mul_result), .res_valid(res_valid), .hi_wdata(hi_wdata),
    .lo_wdata(lo_wdata), .div_timeout(div_timeout)
  );

  // {hi, lo} from plain arithmetic: products, or {remainder, quotient}
  function automatic logic [63:0] ref_hilo(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb;
    int     qa, qb;
    sa = $signed(a);
    sb = $signed(b);
    qa = a;
    qb = b;
    case (op)
      2'b00:   return sa * sb;
      2'b01:   return {32'd0, a} * {32'd0, b};
      2'b10:   return {32'(qa % qb), 32'(qa / qb)};
      default: return {a % b, a / b};
    endcase
  endfunction

  // multiplier: MUL_LAT-deep pipeline of the operands presented each cycle
  logic [63:0] mpipe [0:15];
  always @(posedge clk) begin
    mpipe[0] <= ref_hilo({1'b0, ~mul_signed}, src_a, src_b);
    for (int i = 1; i < 16; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_result = mpipe[MUL_LAT-1];

  // divider: latches operands on start, ready div_lat cycles later (0 = never)
  logic        dbusy = 1'b0, ds = 1'b0;
  int          dcnt = 0, div_lat = 0, starts = 0;
  logic [31:0] da = '0, db = 32'd1;
  assign div_ready  = dbusy && (div_lat != 0) && (dcnt == div_lat);
  assign div_result = dbusy ? ref_hilo({1'b1, ~ds}, da, db) : 64'hDEAD_BEEF_DEAD_BEEF;
  always @(posedge clk) begin
    if (rst) dbusy <= 1'b0;
    else if (dbusy) begin
      if (div_ready || div_annul) dbusy <= 1'b0;
      else dcnt <= dcnt + 1;
    end else if (div_start) begin
      dbusy  <= 1'b1;
      dcnt   <= 1;
      da     <= div_opa;
      db     <= div_opb;
      ds     <= div_signed;
      starts <= starts + 1;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // issue one op, follow it to DONE, hold it, then accept it
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int dlat, input int hold,
                        input logic [63:0] exp_hilo, input int exp_lat,
                        input logic exp_to, input logic exp_start);
    int t, st, ann, ann_t, bad, bad2, s0;
    s0 = starts;
    div_lat = dlat;
    op_valid = 1'b1; op_sel = op; src_a = a; src_b = b; op_accept = 1'b0;
    #1;
    t = 0; st = 0; ann = 0; ann_t = -1; bad = 0; bad2 = 0;
    while (res_valid !== 1'b1 && t < 400) begin
      if (stallreq === 1'b1) st++;
      if (div_annul === 1'b1) begin ann++; ann_t = t; end
      else if (div_start !== (exp_start && !div_ready)) bad++;
      if (div_start === 1'b1 && (div_opa !== a || div_opb !== b)) bad++;
      if (div_start !== 1'b1 && (div_opa !== 32'd0 || div_opb !== 32'd0)) bad++;
      step;
      t++;
    end
    chk({tag, " latency"}, t, exp_lat);
    chk({tag, " stall_cycles"}, st, exp_lat);
    chk({tag, " annul_count"}, ann, exp_to ? 1 : 0);
    chk({tag, " annul_cycle"}, ann_t, exp_to ? DIV_MAX_CYC : -1);
    chk({tag, " start_level"}, bad, 0);
    chk({tag, " hilo"}, {hi_wdata, lo_wdata}, exp_hilo);
    chk({tag, " timeout"}, div_timeout, exp_to);
    chk({tag, " stall_in_done"}, stallreq, 1'b0);
    for (int i = 0; i < hold; i++) begin
      step;
      if (res_valid !== 1'b1 || {hi_wdata, lo_wdata} !== exp_hilo ||
          div_start !== 1'b0 || stallreq !== 1'b0) bad2++;
    end
    chk({tag, " hold_stable"}, bad2, 0);
    op_accept = 1'b1;
    step;
    op_accept = 1'b0; op_valid = 1'b0;
    #1;
    chk({tag, " released"}, res_valid, 1'b0);
    chk({tag, " starts"}, starts - s0, exp_start ? 1 : 0);
  endtask

  initial begin
    int s0;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          rl;

    // reset with a divide presented: nothing may start
    op_valid = 1'b1; op_sel = 2'b10; src_a = 32'd5; src_b = 32'd3;
    #1;
    chk("rst_comb", {stallreq, div_start, div_annul}, 3'b000);
    step; step;
    chk("rst_comb2", {stallreq, div_start, div_annul}, 3'b000);
    op_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_state", {res_valid, hi_wdata, lo_wdata, div_timeout, div_annul, stallreq,
                      div_start}, '0);
    chk("rst_starts", starts, 0);

    run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'd2, 0, 0, 64'h0000_0001_FFFF_FFFE,
           MUL_LAT + 1, 1'b0, 1'b0);
    run_op("mult", 2'b00, 32'hFFFF_FFFF, 32'd2, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE,
           MUL_LAT + 1, 1'b0, 1'b0);
    run_op("divu", 2'b11, 32'd100, 32'd7, 33, 0, 64'h0000_0002_0000_000E,
           34, 1'b0, 1'b1);
    run_op("div_hold", 2'b10, 32'hFFFF_FFF9, 32'd2, 33, 5, 64'hFFFF_FFFF_FFFF_FFFD,
           34, 1'b0, 1'b1);

    // flush on DIV_RUN cycle 10, coinciding with div_ready
    s0 = starts;
    div_lat = 10;
    op_valid = 1'b1; op_sel = 2'b11; src_a = 32'd100; src_b = 32'd7;
    #1;
    for (int i = 0; i < 10; i++) step;
    chk("flush_ready_seen", div_ready, 1'b1);
    flush = 1'b1; op_valid = 1'b0;
    #1;
    chk("flush_annul", div_annul, 1'b1);
    chk("flush_nostart", {div_start, stallreq}, 2'b00);
    step;
    flush = 1'b0;
    #1;
    chk("flush_no_capture", res_valid, 1'b0);
    chk("flush_annul_pulse", div_annul, 1'b0);
    repeat (3) step;
    chk("flush_idle", {res_valid, stallreq, div_start}, 3'b000);
    chk("flush_starts", starts - s0, 1);

    run_op("timeout", 2'b10, 32'd50, 32'd5, 0, 2, 64'h0, DIV_MAX_CYC + 1, 1'b1, 1'b1);
    run_op("to_clear", 2'b01, 32'd3, 32'd4, 0, 0, 64'd12, MUL_LAT + 1, 1'b0, 1'b0);
    run_op("ready_at_limit", 2'b11, 32'd1000, 32'd3, DIV_MAX_CYC, 0,
           {32'd1, 32'd333}, DIV_MAX_CYC + 1, 1'b0, 1'b1);

    // reset in the middle of a divide
    div_lat = 0;
    op_valid = 1'b1; op_sel = 2'b10; src_a = 32'd9; src_b = 32'd2;
    #1;
    repeat (5) step;
    rst = 1'b1;
    #1;
    chk("rst_mid_no_annul", {div_annul, div_start, stallreq}, 3'b000);
    step;
    rst = 1'b0; op_valid = 1'b0;
    #1;
    chk("rst_mid_idle", {res_valid, stallreq, div_timeout}, 3'b000);

`ifdef MULDIV_DIVZERO_EN
    run_op("divzero", 2'b10, 32'h0000_1234, 32'd0, 0, 1, 64'h0000_1234_FFFF_FFFF,
           1, 1'b0, 1'b0);
`endif

    for (int k = 0; k < 10; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (rop[1] && rb == 32'd0) rb = 32'd1;
      if (rop == 2'b10 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      rl = $urandom_range(1, DIV_MAX_CYC - 1);
      run_op($sformatf("rand%0d", k), rop, ra, rb, rl, $urandom_range(0, 3),
             ref_hilo(rop, ra, rb), rop[1] ? rl + 1 : MUL_LAT + 1, 1'b0, rop[1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
